// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch front end.
// Entry layout is the packed record carried through the fetch queue.
package cpu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [ILEN-1:0] EOP_INSTR = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc_4;
        logic            eop;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic {
        FS_FETCH = 1'b0,
        FS_HALT  = 1'b1
    } fetch_state_t;

    function automatic logic is_eop(input logic [ILEN-1:0] instr);
        return instr == EOP_INSTR;
    endfunction

    function automatic fetch_entry_t make_entry(input logic [ILEN-1:0] instr,
                                                input logic [XLEN-1:0] pc);
        fetch_entry_t e;
        e.instr = instr;
        e.pc_4  = pc + XLEN'(4);
        e.eop   = is_eop(instr);
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted only when
// a pop happens in the same cycle. Flush empties it and rewinds both pointers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !i_flush && !o_empty;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the count alone.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Fetch front end: owns fetch PC, queues fetched words with PC+4 and EOP flag,
// and hands them to decode over valid/ready; redirects flush wrong-path words.
//
//  state    | meaning
//  FS_FETCH | one imem word pushed per cycle whenever the queue has room
//  FS_HALT  | EOP word queued; fetch PC frozen until redirect or reset
module instruction_fetch_buffer
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [ILEN-1:0] i_imem_instr,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_decode_ready,
    output logic            o_out_valid,
    output logic [ILEN-1:0] o_out_instr,
    output logic [XLEN-1:0] o_out_pc_4,
    output logic            o_out_eop
);

    localparam int COUNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [XLEN-1:0]   r_fetch_pc;

    fetch_entry_t      w_wr_entry;
    fetch_entry_t      w_head;
    logic [COUNT_W-1:0] w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;

    assign w_out_valid = !w_empty;
    assign w_pop       = w_out_valid && i_decode_ready && !i_redirect_valid;
    assign w_push      = !i_redirect_valid && (r_state == FS_FETCH)
                         && ((w_count < COUNT_W'(DEPTH)) || w_pop);
    assign w_wr_entry  = make_entry(i_imem_instr, r_fetch_pc);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect_valid),
        .i_wdata (w_wr_entry),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= FS_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_redirect_valid) begin
            w_state_next = FS_FETCH;
        end else if (w_push && w_wr_entry.eop) begin
            w_state_next = FS_HALT;
        end
    end

    // Redirect target is used verbatim, including any misaligned low bits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (i_redirect_valid) begin
            r_fetch_pc <= i_redirect_pc;
        end else if (w_push) begin
            r_fetch_pc <= w_wr_entry.pc_4;
        end
    end

    assign o_imem_addr = r_fetch_pc;

    always_comb begin
        o_out_valid = w_out_valid;
        o_out_instr = NOP_INSTR;
        o_out_pc_4  = '0;
        o_out_eop   = 1'b0;
        if (w_out_valid) begin
            o_out_instr = w_head.instr;
            o_out_pc_4  = w_head.pc_4;
            o_out_eop   = w_head.eop;
        end
    end

    a_count_bound: assert property (@(posedge i_clk) disable iff (i_reset)
        (w_count <= COUNT_W'(DEPTH)) && (w_full == (w_count == COUNT_W'(DEPTH))));

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Directed bench for instruction_fetch_buffer: vector table for streaming,
// backpressure and redirect, plus hand sequences for EOP/redirect/reset corners.
module tb_instruction_fetch_buffer;

    logic        clk;
    logic        rst;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc_4;
    logic        out_eop;
    logic [63:0] eop_addr;

    int n_tests;
    int n_fail;

    localparam logic [63:0] NO_EOP = 64'hFFFF_FFFF_FFFF_FFF1;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        exp_valid;
        logic [63:0] exp_pc4;
        logic [63:0] exp_addr;
        logic        exp_eop;
    } vec_t;

    vec_t vecs[$];

    instruction_fetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .o_imem_addr      (imem_addr),
        .i_imem_instr     (imem_instr),
        .i_redirect_valid (rv),
        .i_redirect_pc    (rpc),
        .i_decode_ready   (rdy),
        .o_out_valid      (out_valid),
        .o_out_instr      (out_instr),
        .o_out_pc_4       (out_pc_4),
        .o_out_eop        (out_eop)
    );

    function automatic logic [31:0] tag(input logic [63:0] a);
        return a[31:0] + 32'h1000_0000;
    endfunction

    assign imem_instr = (imem_addr == eop_addr) ? 32'hFFFF_FFFF : tag(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addv(input logic r, input logic v, input logic [63:0] p, input logic d,
                        input logic ev, input logic [63:0] epc4, input logic [63:0] eaddr,
                        input logic eeop);
        vec_t t;
        t.rst = r; t.rv = v; t.rpc = p; t.rdy = d;
        t.exp_valid = ev; t.exp_pc4 = epc4; t.exp_addr = eaddr; t.exp_eop = eeop;
        vecs.push_back(t);
    endtask

    task automatic step(input logic r, input logic v, input logic [63:0] p, input logic d);
        rst = r; rv = v; rpc = p; rdy = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic [63:0] epc4,
                         input logic [63:0] eaddr, input logic eeop);
        logic [31:0] ei;
        if (!ev)       ei = 32'h0000_0013;
        else if (eeop) ei = 32'hFFFF_FFFF;
        else           ei = tag(epc4 - 64'd4);
        n_tests++;
        if (out_valid !== ev || out_pc_4 !== (ev ? epc4 : 64'h0) || imem_addr !== eaddr
            || out_eop !== (ev && eeop) || out_instr !== ei) begin
            n_fail++;
            $display("FAIL %s: actual valid=%0b pc_4=%h addr=%h eop=%0b instr=%h | expected valid=%0b pc_4=%h addr=%h eop=%0b instr=%h",
                     name, out_valid, out_pc_4, imem_addr, out_eop, out_instr,
                     ev, (ev ? epc4 : 64'h0), eaddr, (ev && eeop), ei);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        eop_addr = NO_EOP;
        rst = 1'b1; rv = 1'b0; rpc = '0; rdy = 1'b0;

        // streaming with decode always ready
        addv(1, 0, 0, 1,  0, 64'h0,  64'h0,  0);
        addv(0, 0, 0, 1,  1, 64'h4,  64'h4,  0);
        addv(0, 0, 0, 1,  1, 64'h8,  64'h8,  0);
        addv(0, 0, 0, 1,  1, 64'hC,  64'hC,  0);
        addv(0, 0, 0, 1,  1, 64'h10, 64'h10, 0);
        // backpressure: exactly four pushes, then drain in order
        addv(1, 0, 0, 0,  0, 64'h0,  64'h0,  0);
        addv(0, 0, 0, 0,  1, 64'h4,  64'h4,  0);
        addv(0, 0, 0, 0,  1, 64'h4,  64'h8,  0);
        addv(0, 0, 0, 0,  1, 64'h4,  64'hC,  0);
        addv(0, 0, 0, 0,  1, 64'h4,  64'h10, 0);
        for (int k = 0; k < 6; k++) addv(0, 0, 0, 0, 1, 64'h4, 64'h10, 0);
        addv(0, 0, 0, 1,  1, 64'h8,  64'h14, 0);
        addv(0, 0, 0, 1,  1, 64'hC,  64'h18, 0);
        addv(0, 0, 0, 1,  1, 64'h10, 64'h1C, 0);
        addv(0, 0, 0, 1,  1, 64'h14, 64'h20, 0);
        addv(0, 0, 0, 1,  1, 64'h18, 64'h24, 0);
        // redirect with three queued entries
        addv(1, 0, 0, 0,  0, 64'h0,  64'h0,  0);
        addv(0, 0, 0, 0,  1, 64'h4,  64'h4,  0);
        addv(0, 0, 0, 0,  1, 64'h4,  64'h8,  0);
        addv(0, 0, 0, 0,  1, 64'h4,  64'hC,  0);
        addv(0, 1, 64'h100, 1,  0, 64'h0, 64'h100, 0);
        addv(0, 0, 0, 1,  1, 64'h104, 64'h104, 0);
        addv(0, 0, 0, 1,  1, 64'h108, 64'h108, 0);
        // misaligned target passes through
        addv(0, 1, 64'h203, 1,  0, 64'h0, 64'h203, 0);
        addv(0, 0, 0, 1,  1, 64'h207, 64'h207, 0);
        // fetch PC wraps at 2^64
        addv(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1,  0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        addv(0, 0, 0, 1,  1, 64'h0, 64'h0, 0);
        addv(0, 0, 0, 1,  1, 64'h4, 64'h4, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc4,
                  vecs[i].exp_addr, vecs[i].exp_eop);
        end

        // EOP at address 8 halts fetch after three entries
        eop_addr = 64'h8;
        step(1, 0, 0, 1); check("eop_rst",   0, 64'h0, 64'h0, 0);
        step(0, 0, 0, 1); check("eop_w0",    1, 64'h4, 64'h4, 0);
        step(0, 0, 0, 1); check("eop_w4",    1, 64'h8, 64'h8, 0);
        step(0, 0, 0, 1); check("eop_w8",    1, 64'hC, 64'hC, 1);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1); check($sformatf("eop_hold%0d", k), 0, 64'h0, 64'hC, 0);
        end

        // redirect while the EOP word is on the imem bus
        step(1, 0, 0, 1); check("rde_rst",   0, 64'h0, 64'h0, 0);
        step(0, 0, 0, 1); check("rde_w0",    1, 64'h4, 64'h4, 0);
        step(0, 0, 0, 1); check("rde_w4",    1, 64'h8, 64'h8, 0);
        step(0, 1, 64'h40, 1); check("rde_redir", 0, 64'h0, 64'h40, 0);
        step(0, 0, 0, 1); check("rde_w40",   1, 64'h44, 64'h44, 0);
        step(0, 0, 0, 1); check("rde_w44",   1, 64'h48, 64'h48, 0);
        // redirect while already halted
        eop_addr = 64'h4C;
        step(0, 0, 0, 1); check("rdh_w48",   1, 64'h4C, 64'h4C, 0);
        step(0, 0, 0, 1); check("rdh_eop",   1, 64'h50, 64'h50, 1);
        step(0, 1, 64'h80, 1); check("rdh_redir", 0, 64'h0, 64'h80, 0);
        step(0, 0, 0, 1); check("rdh_w80",   1, 64'h84, 64'h84, 0);

        // reset beats redirect with a full queue
        eop_addr = NO_EOP;
        step(0, 0, 0, 0); check("rst_fill1", 1, 64'h84, 64'h88, 0);
        step(0, 0, 0, 0); check("rst_fill2", 1, 64'h84, 64'h8C, 0);
        step(0, 0, 0, 0); check("rst_fill3", 1, 64'h84, 64'h90, 0);
        step(0, 0, 0, 0); check("rst_full",  1, 64'h84, 64'h90, 0);
        step(1, 1, 64'h300, 1); check("rst_win", 0, 64'h0, 64'h0, 0);
        step(0, 0, 0, 1); check("rst_after", 1, 64'h4, 64'h4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
